polaris_fetch_unit: RTL and testbench

POLARIS_FETCH_UNIT -- requirements
Module: polaris_fetch_unit

---
 rtl/polaris_fetch_unit.sv | 137 +++++++++++++
 tb/tb_polaris_fetch_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/polaris_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : polaris_fetch_unit
// Purpose  : Instruction fetch with prefetch queue, redirect flush and
//            optional misaligned-redirect trap (POLARIS_MISALIGN_TRAP_EN).
// Revision : 1.0
// ============================================================================
module polaris_fetch_unit #(
    parameter int unsigned    AW           = 64,
    parameter int unsigned    DEPTH        = 4,
    parameter logic [AW-1:0]  RESET_VECTOR = AW'(64'hFFFF_FFFF_FFFF_FF00)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     iack_i,
    input  logic [31:0]              idat_i,
    output logic [AW-1:0]            iadr_o,
    output logic [1:0]               isiz_o,
    input  logic                     redirect_i,
    input  logic [AW-1:0]            redirect_adr_i,
    output logic                     ir_valid_o,
    output logic [31:0]              ir_o,
    output logic [AW-1:0]            ir_pc_o,
    input  logic                     ir_take_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     fault_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [AW-1:0]  fpc_q;
    logic [LW-1:0]  level_q, level_d;
    logic [PW-1:0]  head_q, tail_q;
    logic [AW-1:0]  pc_mem_q  [DEPTH];
    logic [31:0]    ins_mem_q [DEPTH];

    logic           do_push;
    logic           do_pop;
    logic           misaligned;
    logic           trap_en;
    logic [AW-1:0]  redir_adr;

`ifdef POLARIS_MISALIGN_TRAP_EN
    assign trap_en    = 1'b1;
    assign misaligned = (redirect_adr_i[1:0] != 2'b00);
    assign redir_adr  = redirect_adr_i;
`else
    assign trap_en    = 1'b0;
    assign misaligned = 1'b0;
    assign redir_adr  = redirect_adr_i & ~AW'(3);
`endif

    // Redirect discards both the coincident acknowledge and the coincident pop.
    assign do_push = (state_q == S_FETCH) & iack_i & ~redirect_i;
    assign do_pop  = ir_take_i & (level_q != '0) & ~redirect_i;
    assign level_d = level_q + LW'(do_push) - LW'(do_pop);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_i) begin
            state_d = misaligned ? S_FAULT : S_FETCH;
        end else begin
            case (state_q)
                S_RESET: state_d = S_FETCH;
                S_FETCH: if (level_d == LW'(DEPTH)) state_d = S_FULL;
                S_FULL:  if (level_d != LW'(DEPTH)) state_d = S_FETCH;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        isiz_o  = 2'b00;
        iadr_o  = '0;
        fault_o = 1'b0;
        case (state_q)
            S_FETCH: begin
                isiz_o = 2'b10;
                iadr_o = fpc_q;
            end
            S_FAULT: fault_o = trap_en;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fpc_q   <= RESET_VECTOR;
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else if (redirect_i) begin
            fpc_q   <= redir_adr;
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            level_q <= level_d;
            if (do_push) begin
                fpc_q  <= fpc_q + AW'(4);
                tail_q <= tail_q + PW'(1);
            end
            if (do_pop) begin
                head_q <= head_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !reset_i) begin
            pc_mem_q[tail_q]  <= fpc_q;
            ins_mem_q[tail_q] <= idat_i;
        end
    end

    assign ir_valid_o = (level_q != '0);
    assign ir_o       = ir_valid_o ? ins_mem_q[head_q] : '0;
    assign ir_pc_o    = ir_valid_o ? pc_mem_q[head_q]  : '0;
    assign level_o    = level_q;

endmodule
`default_nettype wire

// File: tb/tb_polaris_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_polaris_fetch_unit
// Purpose  : Scoreboard bench for polaris_fetch_unit with a queue-level model.
// Revision : 1.0
// ============================================================================
module tb_polaris_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [63:0] RV    = 64'hFFFF_FFFF_FFFF_FF00;
`ifdef POLARIS_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } entry_t;

    logic        clk;
    logic        reset_i = 1'b1, iack_i = 1'b0, redirect_i = 1'b0, ir_take_i = 1'b0;
    logic [31:0] idat_i = '0;
    logic [63:0] redirect_adr_i = '0;
    logic [63:0] iadr_o, ir_pc_o;
    logic [1:0]  isiz_o;
    logic        ir_valid_o, fault_o;
    logic [31:0] ir_o;
    logic [2:0]  level_o;

    logic        r32 = 1'b1, ack32 = 1'b0;
    logic [31:0] iadr32, irpc32, ir32;
    logic [1:0]  isiz32;
    logic        valid32, fault32;
    logic [2:0]  level32;

    int checks = 0;
    int errors = 0;

    entry_t      exp_q[$];
    logic [63:0] m_fpc   = RV;
    bit          m_rst   = 1'b1;
    bit          m_fault = 1'b0;
    bit          pend_req;
    bit          mon_en  = 1'b0;
    bit          done32  = 1'b0;

    polaris_fetch_unit #(.AW(64), .DEPTH(DEPTH), .RESET_VECTOR(RV)) u_dut (
        .clk_i(clk), .reset_i(reset_i), .iack_i(iack_i), .idat_i(idat_i),
        .iadr_o(iadr_o), .isiz_o(isiz_o), .redirect_i(redirect_i),
        .redirect_adr_i(redirect_adr_i), .ir_valid_o(ir_valid_o), .ir_o(ir_o),
        .ir_pc_o(ir_pc_o), .ir_take_i(ir_take_i), .level_o(level_o), .fault_o(fault_o)
    );

    polaris_fetch_unit #(.AW(32), .DEPTH(4), .RESET_VECTOR(32'hFFFF_FFFC)) u_dut32 (
        .clk_i(clk), .reset_i(r32), .iack_i(ack32), .idat_i(32'h1234_5678),
        .iadr_o(iadr32), .isiz_o(isiz32), .redirect_i(1'b0),
        .redirect_adr_i(32'h0), .ir_valid_o(valid32), .ir_o(ir32),
        .ir_pc_o(irpc32), .ir_take_i(1'b0), .level_o(level32), .fault_o(fault32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Fetch is requested whenever the unit is out of reset, not trapped and has room.
    function automatic bit model_req();
        return !m_rst && !m_fault && (exp_q.size() < DEPTH);
    endfunction

    function automatic void model_step();
        if (reset_i) begin
            m_rst = 1'b1; m_fault = 1'b0; m_fpc = RV; exp_q.delete();
        end else if (redirect_i) begin
            m_rst = 1'b0;
            exp_q.delete();
            m_fault = TRAP && (redirect_adr_i[1:0] != 2'b00);
            m_fpc   = TRAP ? redirect_adr_i : {redirect_adr_i[63:2], 2'b00};
        end else begin
            m_rst = 1'b0;
            if (pend_req && iack_i) begin
                exp_q.push_back('{pc: m_fpc, ins: idat_i});
                m_fpc = m_fpc + 64'd4;
            end
        end
    endfunction

    task automatic cycle(input bit rst, input bit ack, input bit take,
                         input bit redir, input logic [63:0] radr);
        @(negedge clk);
        reset_i = rst; iack_i = ack; ir_take_i = take;
        redirect_i = redir; redirect_adr_i = radr; idat_i = $urandom;
        pend_req = model_req();
        @(posedge clk);
        #1;
        model_step();
    endtask

    // Monitor: compares every cycle and pops the scoreboard when the head is consumed.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                check("isiz", {62'd0, isiz_o}, model_req() ? 64'd2 : 64'd0);
                check("iadr", iadr_o, model_req() ? m_fpc : 64'd0);
                check("level", {61'd0, level_o}, 64'(exp_q.size()));
                check("valid", {63'd0, ir_valid_o}, {63'd0, exp_q.size() != 0});
                check("fault", {63'd0, fault_o}, {63'd0, m_fault});
                if (!ir_valid_o) begin
                    check("ir_zero", {32'd0, ir_o}, 64'd0);
                    check("pc_zero", ir_pc_o, 64'd0);
                end else if (ir_take_i && !reset_i && !redirect_i) begin
                    if (exp_q.size() == 0) begin
                        check("pop_empty", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pop_pc", ir_pc_o, e.pc);
                        check("pop_ins", {32'd0, ir_o}, {32'd0, e.ins});
                    end
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        @(negedge clk) r32 = 1'b0;
        @(posedge clk) #4;
        check("aw32_first", {32'd0, iadr32}, 64'h0000_0000_FFFF_FFFC);
        @(negedge clk) ack32 = 1'b1;
        @(posedge clk) #4;
        check("aw32_wrap", {32'd0, iadr32}, 64'd0);
        check("aw32_pc", {32'd0, irpc32}, 64'h0000_0000_FFFF_FFFC);
        @(negedge clk) ack32 = 1'b0;
        done32 = 1'b1;
    end

    initial begin
        logic [63:0] radr;
        bit rst, redir;

        cycle(1, 0, 0, 0, 0);
        mon_en = 1'b1;
        cycle(1, 1, 1, 0, 0);
        check("rst_isiz", {62'd0, isiz_o}, 64'd0);
        check("rst_level", {61'd0, level_o}, 64'd0);
        cycle(0, 0, 0, 0, 0);
        check("first_adr", iadr_o, RV);
        check("first_isiz", {62'd0, isiz_o}, 64'd2);
        repeat (2) begin
            cycle(0, 0, 0, 0, 0);
            check("wait_adr", iadr_o, RV);
        end

        repeat (4) cycle(0, 1, 0, 0, 0);
        check("full_level", {61'd0, level_o}, 64'd4);
        check("full_isiz", {62'd0, isiz_o}, 64'd0);
        cycle(0, 1, 0, 0, 0);
        check("full_ignack", {61'd0, level_o}, 64'd4);
        cycle(0, 0, 1, 0, 0);
        check("resume_adr", iadr_o, RV + 64'h10);

        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 1, 0, 0);
            check("flow_level", {61'd0, level_o}, 64'd1);
            check("flow_pc", ir_pc_o, RV + 64'(4 * i));
        end

        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        repeat (3) cycle(0, 1, 0, 0, 0);
        check("pre_redir_lvl", {61'd0, level_o}, 64'd3);
        cycle(0, 1, 1, 1, 64'h100);
        check("redir_level", {61'd0, level_o}, 64'd0);
        check("redir_valid", {63'd0, ir_valid_o}, 64'd0);
        check("redir_adr", iadr_o, 64'h100);

        cycle(0, 1, 0, 1, 64'h102);
        if (TRAP) begin
            check("trap_fault", {63'd0, fault_o}, 64'd1);
            check("trap_isiz", {62'd0, isiz_o}, 64'd0);
            cycle(0, 1, 0, 1, 64'h104);
            check("trap_clear", {63'd0, fault_o}, 64'd0);
            check("trap_adr", iadr_o, 64'h104);
        end else begin
            check("mis_adr", iadr_o, 64'h100);
            check("mis_fault", {63'd0, fault_o}, 64'd0);
        end

        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            redir = ($urandom_range(0, 29) == 0);
            radr  = {$urandom, $urandom};
            if ($urandom_range(0, 4) != 0) radr[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) radr = 64'hFFFF_FFFF_FFFF_FFF0;
            cycle(rst, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, redir, radr);
        end

        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 20 && !done32; i++) @(negedge clk);
        if (!done32) check("aw32_done", 64'd0, 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
